// File: rtl/pe_mac_fp8_v2.sv
// Systolic PE: FP8 (E4M3/E5M2) x FP8 multiply into a saturating signed fixed-point
// accumulator, with operand forwarding, sticky flags, a MAC counter and a BF16 view of C.
module pe_mac_fp8_v2 #(
  parameter int ACC_W     = 24,
  parameter int FRAC_BITS = 10,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic             fmt,
  input  logic [7:0]       a_in,
  input  logic [7:0]       b_in,
  output logic [7:0]       a_out,
  output logic [7:0]       b_out,
  output logic             out_valid,
  output logic [15:0]      c_out,
  output logic             c_valid,
  output logic [CNT_W-1:0] mac_cnt,
  output logic             nan_flag,
  output logic             ovf_flag
);

  localparam int MAG_W = ACC_W + 8;
  localparam logic [ACC_W-1:0] MAXV  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] NMAXV = {1'b1, {(ACC_W-2){1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] SMAX = $signed({2'b00, {(ACC_W-1){1'b1}}});

  typedef struct packed {
    logic              special;
    logic              sign;
    logic signed [6:0] exp;
    logic [3:0]        sig;
  } fp_dec_t;

  function automatic fp_dec_t decode(input logic [7:0] x, input logic f);
    fp_dec_t d;
    d.sign = x[7];
    if (!f) begin
      d.special = (x[6:0] == 7'h7F);
      d.sig     = {(x[6:3] != 4'd0), x[2:0]};
      d.exp     = (x[6:3] == 4'd0) ? -7'sd6 : $signed({3'b000, x[6:3]}) - 7'sd7;
    end else begin
      // E5M2 mantissa is left-justified so both formats share a 1.3 significand
      d.special = (x[6:2] == 5'h1F);
      d.sig     = {(x[6:2] != 5'd0), x[1:0], 1'b0};
      d.exp     = (x[6:2] == 5'd0) ? -7'sd14 : $signed({2'b00, x[6:2]}) - 7'sd15;
    end
    return d;
  endfunction

  // Returns {clamped, magnitude}; product has 6 fraction bits, truncates toward zero.
  function automatic logic [ACC_W:0] align_sat(input logic [7:0] prod, input logic signed [6:0] e);
    int             sh;
    logic [MAG_W-1:0] wide;
    logic           ovf;
    sh   = int'(e) + FRAC_BITS - 6;
    wide = '0;
    ovf  = 1'b0;
    if (sh >= ACC_W)   ovf  = (prod != 8'd0);
    else if (sh >= 0)  wide = MAG_W'(prod) << sh;
    else if (sh > -8)  wide = MAG_W'(prod) >> (-sh);
    if (wide > MAG_W'(MAXV)) ovf = 1'b1;
    if (ovf) return {1'b1, MAXV};
    return {1'b0, wide[ACC_W-1:0]};
  endfunction

  function automatic logic [ACC_W:0] acc_add(input logic signed [ACC_W-1:0] acc,
                                             input logic [ACC_W-1:0] mag, input logic neg);
    logic signed [ACC_W:0] s;
    logic signed [ACC_W:0] m;
    m = $signed({1'b0, mag});
    s = neg ? ($signed({acc[ACC_W-1], acc}) - m) : ($signed({acc[ACC_W-1], acc}) + m);
    if (s > SMAX)  return {1'b1, MAXV};
    if (s < -SMAX) return {1'b1, NMAXV};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  function automatic logic [15:0] to_bf16(input logic signed [ACC_W-1:0] a, input logic nan);
    logic [ACC_W-1:0] mag;
    logic [ACC_W-1:0] norm;
    int               p;
    if (nan)      return 16'h7FC0;
    if (a == '0)  return 16'h0000;
    mag = a[ACC_W-1] ? (~a + 1'b1) : a;
    p   = 0;
    for (int i = 0; i < ACC_W; i++) if (mag[i]) p = i;
    norm = mag << (ACC_W - 1 - p);
    return {a[ACC_W-1], 8'(p - FRAC_BITS + 127), norm[ACC_W-2 -: 7]};
  endfunction

  logic [7:0]              a_out_q, a_out_d, b_out_q, b_out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    vld_p1_q, vld_p1_d, sign_p1_q, sign_p1_d, spec_p1_q, spec_p1_d;
  logic [7:0]              prod_p1_q, prod_p1_d;
  logic signed [6:0]       exp_p1_q, exp_p1_d;
  logic signed [ACC_W-1:0] acc_p2_q, acc_p2_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    nan_q, nan_d, ovf_q, ovf_d, c_valid_q, c_valid_d;
  logic [15:0]             c_out_q, c_out_d;

  always_comb begin
    fp_dec_t         da;
    fp_dec_t         db;
    logic [ACC_W:0]  al;
    logic [ACC_W:0]  ad;
    da = decode(a_in, fmt);
    db = decode(b_in, fmt);
    al = '0;
    ad = '0;

    a_out_d     = a_in;
    b_out_d     = b_in;
    out_valid_d = in_valid;

    // Stage 1: significand product and exponent sum
    vld_p1_d  = in_valid;
    sign_p1_d = da.sign ^ db.sign;
    spec_p1_d = da.special | db.special;
    prod_p1_d = {4'b0, da.sig} * {4'b0, db.sig};
    exp_p1_d  = da.exp + db.exp;

    // Stage 2: align, saturate, accumulate; clear also drops the product in stage 1
    acc_p2_d  = acc_p2_q;
    cnt_d     = cnt_q;
    nan_d     = nan_q;
    ovf_d     = ovf_q;
    c_valid_d = c_valid_q;
    if (clear) begin
      acc_p2_d  = '0;
      cnt_d     = '0;
      nan_d     = 1'b0;
      ovf_d     = 1'b0;
      c_valid_d = 1'b0;
    end else if (vld_p1_q) begin
      if (spec_p1_q) begin
        nan_d = 1'b1;
      end else begin
        al        = align_sat(prod_p1_q, exp_p1_q);
        ad        = acc_add(acc_p2_q, al[ACC_W-1:0], sign_p1_q);
        acc_p2_d  = ad[ACC_W-1:0];
        ovf_d     = ovf_q | al[ACC_W] | ad[ACC_W];
        cnt_d     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        c_valid_d = 1'b1;
      end
    end

    // Output stage
    c_out_d = to_bf16(acc_p2_q, nan_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_out_q     <= '0;
      b_out_q     <= '0;
      out_valid_q <= 1'b0;
      vld_p1_q    <= 1'b0;
      sign_p1_q   <= 1'b0;
      spec_p1_q   <= 1'b0;
      prod_p1_q   <= '0;
      exp_p1_q    <= '0;
      acc_p2_q    <= '0;
      cnt_q       <= '0;
      nan_q       <= 1'b0;
      ovf_q       <= 1'b0;
      c_valid_q   <= 1'b0;
      c_out_q     <= '0;
    end else begin
      a_out_q     <= a_out_d;
      b_out_q     <= b_out_d;
      out_valid_q <= out_valid_d;
      vld_p1_q    <= vld_p1_d;
      sign_p1_q   <= sign_p1_d;
      spec_p1_q   <= spec_p1_d;
      prod_p1_q   <= prod_p1_d;
      exp_p1_q    <= exp_p1_d;
      acc_p2_q    <= acc_p2_d;
      cnt_q       <= cnt_d;
      nan_q       <= nan_d;
      ovf_q       <= ovf_d;
      c_valid_q   <= c_valid_d;
      c_out_q     <= c_out_d;
    end
  end

  assign a_out     = a_out_q;
  assign b_out     = b_out_q;
  assign out_valid = out_valid_q;
  assign c_out     = c_out_q;
  assign c_valid   = c_valid_q;
  assign mac_cnt   = cnt_q;
  assign nan_flag  = nan_q;
  assign ovf_flag  = ovf_q;

endmodule

// File: tb/tb_pe_mac_fp8_v2.sv
// Directed bench for pe_mac_fp8_v2: single-product vector table plus hand-built
// sequences for back-to-back streaming, flags, clear-with-input and async reset.
module tb_pe_mac_fp8_v2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        fmt = 1'b0;
  logic [7:0]  a_in = '0;
  logic [7:0]  b_in = '0;
  logic [7:0]  a_out, b_out;
  logic        out_valid, c_valid, nan_flag, ovf_flag;
  logic [15:0] c_out;
  logic [7:0]  mac_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pe_mac_fp8_v2 #(.ACC_W(24), .FRAC_BITS(10), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .fmt(fmt),
    .a_in(a_in), .b_in(b_in), .a_out(a_out), .b_out(b_out), .out_valid(out_valid),
    .c_out(c_out), .c_valid(c_valid), .mac_cnt(mac_cnt), .nan_flag(nan_flag),
    .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fmt;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
    logic [7:0]  cnt;
    logic        nan;
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic f, input logic [7:0] a, input logic [7:0] b,
                       input logic cl);
    in_valid = v;
    fmt      = f;
    a_in     = a;
    b_in     = b;
    clear    = cl;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " c_out"}, 32'(c_out), 32'h0);
    chk({tag, " mac_cnt"}, 32'(mac_cnt), 32'h0);
    chk({tag, " a_out"}, 32'(a_out), 32'h0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'h0);
    chk({tag, " c_valid"}, 32'(c_valid), 32'h0);
    chk({tag, " flags"}, 32'({nan_flag, ovf_flag}), 32'h0);
  endtask

  initial begin
    //            fmt  a      b      c_out     cnt  nan  ovf
    vecs[0]  = '{1'b0, 8'h38, 8'h38, 16'h3F80, 8'd1, 1'b0, 1'b0}; // 1*1
    vecs[1]  = '{1'b0, 8'h40, 8'hB8, 16'hC000, 8'd1, 1'b0, 1'b0}; // 2*-1
    vecs[2]  = '{1'b1, 8'h3C, 8'h40, 16'h4000, 8'd1, 1'b0, 1'b0}; // E5M2 1*2
    vecs[3]  = '{1'b0, 8'h4A, 8'h38, 16'h40A0, 8'd1, 1'b0, 1'b0}; // 5*1
    vecs[4]  = '{1'b0, 8'h01, 8'h01, 16'h0000, 8'd1, 1'b0, 1'b0}; // 2^-18 truncates to 0
    vecs[5]  = '{1'b0, 8'h08, 8'h38, 16'h3C80, 8'd1, 1'b0, 1'b0}; // 2^-6, zero-filled mantissa
    vecs[6]  = '{1'b0, 8'h07, 8'h38, 16'h3C60, 8'd1, 1'b0, 1'b0}; // denormal 7/8*2^-6
    vecs[7]  = '{1'b1, 8'h7C, 8'h3C, 16'h7FC0, 8'd0, 1'b1, 1'b0}; // E5M2 Inf
    vecs[8]  = '{1'b0, 8'h7F, 8'h38, 16'h7FC0, 8'd0, 1'b1, 1'b0}; // E4M3 NaN
    vecs[9]  = '{1'b0, 8'h7E, 8'h7E, 16'h45FF, 8'd1, 1'b0, 1'b1}; // 448^2 saturates
    vecs[10] = '{1'b1, 8'h01, 8'h3C, 16'h0000, 8'd1, 1'b0, 1'b0}; // E5M2 denormal underflow
    vecs[11] = '{1'b1, 8'hC0, 8'h3C, 16'hC000, 8'd1, 1'b0, 1'b0}; // E5M2 -2*1

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single-product vectors, each from a freshly cleared tile
    foreach (vecs[i]) begin
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
      tick();
      drive(1'b1, vecs[i].fmt, vecs[i].a, vecs[i].b, 1'b0);
      tick();
      chk($sformatf("v%0d a_out", i), 32'(a_out), 32'(vecs[i].a));
      chk($sformatf("v%0d b_out", i), 32'(b_out), 32'(vecs[i].b));
      chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'h1);
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      tick();
      chk($sformatf("v%0d out_valid drop", i), 32'(out_valid), 32'h0);
      tick();
      chk($sformatf("v%0d c_out", i), 32'(c_out), 32'(vecs[i].c));
      chk($sformatf("v%0d mac_cnt", i), 32'(mac_cnt), 32'(vecs[i].cnt));
      chk($sformatf("v%0d nan", i), 32'(nan_flag), 32'(vecs[i].nan));
      chk($sformatf("v%0d ovf", i), 32'(ovf_flag), 32'(vecs[i].ovf));
      chk($sformatf("v%0d c_valid", i), 32'(c_valid), 32'(vecs[i].cnt != 8'd0));
      tick();
      chk($sformatf("v%0d c_out hold", i), 32'(c_out), 32'(vecs[i].c));
    end

    // Back-to-back: four 2*-1 then an underflowing product
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, 8'h40, 8'hB8, 1'b0);
      tick();
      if (k == 2) chk("b2b first c_out", 32'(c_out), 32'hC000);
    end
    drive(1'b1, 1'b0, 8'h01, 8'h01, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    tick();
    chk("b2b c_out", 32'(c_out), 32'hC100);
    chk("b2b mac_cnt", 32'(mac_cnt), 32'd5);

    // E5M2 2.0 followed by Inf
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    tick();
    drive(1'b1, 1'b1, 8'h3C, 8'h40, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h7C, 8'h3C, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    chk("inf pre c_out", 32'(c_out), 32'h4000);
    tick();
    chk("inf c_out", 32'(c_out), 32'h7FC0);
    chk("inf nan_flag", 32'(nan_flag), 32'h1);
    chk("inf mac_cnt", 32'(mac_cnt), 32'd1);

    // Saturated accumulator then -1.0: stays saturated-looking, ovf sticky
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    tick();
    drive(1'b1, 1'b0, 8'h7E, 8'h7E, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'hB8, 8'h38, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    chk("sat c_out", 32'(c_out), 32'h45FF);
    chk("sat ovf sticky", 32'(ovf_flag), 32'h1);
    chk("sat mac_cnt", 32'(mac_cnt), 32'd2);

    // Clear with a product in stage 1 and a new input in the same cycle
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    tick();
    drive(1'b1, 1'b0, 8'h4A, 8'h38, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h7F, 8'h38, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h4A, 8'h38, 1'b0);
    tick();
    chk("clr pre c_out", 32'(c_out), 32'h40A0);
    chk("clr pre nan", 32'(nan_flag), 32'h1);
    drive(1'b1, 1'b0, 8'h38, 8'h38, 1'b1);
    tick();
    chk("clr nan cleared", 32'(nan_flag), 32'h0);
    chk("clr mac_cnt zero", 32'(mac_cnt), 32'd0);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    chk("clr c_out zero", 32'(c_out), 32'h0);
    tick();
    chk("clr c_out new", 32'(c_out), 32'h3F80);
    chk("clr mac_cnt", 32'(mac_cnt), 32'd1);
    chk("clr flags", 32'({nan_flag, ovf_flag}), 32'h0);

    // Asynchronous reset in the middle of a stream
    drive(1'b1, 1'b0, 8'h38, 8'h38, 1'b0);
    tick();
    tick();
    tick();
    chk("rst pre c_out", 32'(c_out), 32'h4000);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst async");
    tick();
    tick();
    chk_all_zero("rst hold");
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    tick();
    chk("rst no residue c_out", 32'(c_out), 32'h0);
    chk("rst no residue cnt", 32'(mac_cnt), 32'd0);
    drive(1'b1, 1'b0, 8'h38, 8'h38, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    chk("rst after c_out", 32'(c_out), 32'h3F80);
    chk("rst after cnt", 32'(mac_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
